// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings ({cs_n,ras_n,cas_n,we_n}) and the
// one-hot state encodings of the command arbiter FSM.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_ARBIT = 4'b0010;
  localparam logic [3:0] S_AREF  = 4'b0100;
  localparam logic [3:0] S_GRANT = 4'b1000;

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NCH.
//   req     : per-channel request vector
//   ptr     : channel with highest priority this cycle
//   gnt_oh  : one-hot winner (zero when no request)
//   gnt_idx : winner index (zero when no request)
//   gnt_vld : at least one request asserted
module sdram_rr_arbiter #(
  parameter int unsigned NCH = 2
) (
  input  logic [NCH-1:0]                       req,
  input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ptr,
  output logic [NCH-1:0]                       gnt_oh,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] gnt_idx,
  output logic                                 gnt_vld
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  int unsigned cand;

  // Scan channels in priority order starting at ptr; first hit wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      cand = (32'(ptr) + k) % NCH;
      if (!gnt_vld && ((req & (NCH'(1) << cand)) != '0)) begin
        gnt_vld = 1'b1;
        gnt_idx = IW'(cand);
        gnt_oh  = NCH'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command/bus arbiter: multiplexes the init engine, the auto-refresh
// engine and NCH client engines onto registered SDRAM pin outputs.
//   sclk/srst           : clock, asynchronous active-high reset
//   init_*              : init engine handshake and command/address
//   aref_*              : refresh request/done, command/address, enable
//   cli_*               : per-client request/done/command/address/bank/data,
//                         one-hot enable, abort hint, broadcast read data
//   grant_id            : current/last granted client
//   sdram_*             : registered pin command/address/bank/DQ out/DQ oe
//   sdram_dq_in         : DQ pad input
//   err_timeout         : sticky grant watchdog error
module sdram_cmd_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned AW      = 12,
  parameter int unsigned BW      = 2,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    sclk,
  input  logic                    srst,
  input  logic                    init_done,
  input  logic [3:0]              init_cmd,
  input  logic [AW-1:0]           init_addr,
  input  logic                    aref_ask,
  input  logic                    aref_end,
  input  logic [3:0]              aref_cmd,
  input  logic [AW-1:0]           aref_addr,
  output logic                    aref_en,
  input  logic [NCH-1:0]          cli_ask,
  input  logic [NCH-1:0]          cli_end,
  input  logic [4*NCH-1:0]        cli_cmd,
  input  logic [AW*NCH-1:0]       cli_addr,
  input  logic [BW*NCH-1:0]       cli_bank,
  input  logic [DW*NCH-1:0]       cli_wdata,
  input  logic [NCH-1:0]          cli_oe,
  output logic [NCH-1:0]          cli_en,
  output logic                    cli_abort,
  output logic [DW-1:0]           cli_rdata,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] grant_id,
  output logic [3:0]              sdram_cmd,
  output logic [AW-1:0]           sdram_addr,
  output logic [BW-1:0]           sdram_bank,
  output logic [DW-1:0]           sdram_dq_out,
  output logic                    sdram_dq_oe,
  input  logic [DW-1:0]           sdram_dq_in,
  output logic                    err_timeout
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [3:0]     state, state_nx;
  logic [IW-1:0]  rr_ptr, arb_idx;
  logic [NCH-1:0] arb_oh, gnt_oh;
  logic           arb_vld, arb_take;
  logic [WW-1:0]  wd_cnt;
  logic           wd_hit, wd_fire;

  logic [3:0]     src_cmd;
  logic [AW-1:0]  src_addr;
  logic [BW-1:0]  src_bank;
  logic [DW-1:0]  src_dq;
  logic           src_oe;

  int unsigned    gsel;
  logic [3:0]     g_cmd;
  logic [AW-1:0]  g_addr;
  logic [BW-1:0]  g_bank;
  logic [DW-1:0]  g_dq;
  logic           g_end, g_oe;

  // Granted client's bus slice.
  assign gsel   = 32'(grant_id);
  assign g_cmd  = cli_cmd[gsel*4 +: 4];
  assign g_addr = cli_addr[gsel*AW +: AW];
  assign g_bank = cli_bank[gsel*BW +: BW];
  assign g_dq   = cli_wdata[gsel*DW +: DW];
  assign g_end  = |(cli_end & gnt_oh);
  assign g_oe   = |(cli_oe & gnt_oh);

  // Watchdog fires in the TIMEOUT-th grant cycle (counter starts at 0).
  assign wd_hit = (TIMEOUT != 0) && (wd_cnt == WW'(TIMEOUT - 1));

  sdram_rr_arbiter #(.NCH(NCH)) u_rr (
    .req     (cli_ask),
    .ptr     (rr_ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // State register.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next state, source select and enables.
  always_comb begin
    state_nx  = state;
    src_cmd   = CMD_NOP;
    src_addr  = '0;
    src_bank  = '0;
    src_dq    = '0;
    src_oe    = 1'b0;
    cli_en    = '0;
    cli_abort = 1'b0;
    aref_en   = 1'b0;
    arb_take  = 1'b0;
    wd_fire   = 1'b0;
    case (state)
      S_IDLE: begin
        src_cmd  = init_cmd;
        src_addr = init_addr;
        if (init_done) state_nx = S_ARBIT;
      end
      S_ARBIT: begin
        if (aref_ask) begin
          state_nx = S_AREF;
        end else if (arb_vld) begin
          state_nx = S_GRANT;
          arb_take = 1'b1;
        end
      end
      S_AREF: begin
        aref_en  = 1'b1;
        src_cmd  = aref_cmd;
        src_addr = aref_addr;
        if (aref_end) state_nx = S_ARBIT;
      end
      S_GRANT: begin
        cli_en    = aref_ask ? '0 : gnt_oh;
        cli_abort = aref_ask;
        src_cmd   = g_cmd;
        src_addr  = g_addr;
        src_bank  = g_bank;
        src_dq    = g_dq;
        src_oe    = g_oe;
        if (g_end) begin
          state_nx = S_ARBIT;
        end else if (wd_hit) begin
          // Stuck client: drop the bus without issuing its command.
          state_nx = S_ARBIT;
          src_cmd  = CMD_NOP;
          src_oe   = 1'b0;
          wd_fire  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pin registers, grant bookkeeping, watchdog and read-data capture.
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      sdram_cmd    <= CMD_NOP;
      sdram_addr   <= '0;
      sdram_bank   <= '0;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
      cli_rdata    <= '0;
      grant_id     <= '0;
      gnt_oh       <= '0;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      err_timeout  <= 1'b0;
    end else begin
      sdram_cmd    <= src_cmd;
      sdram_addr   <= src_addr;
      sdram_bank   <= src_bank;
      sdram_dq_out <= src_dq;
      sdram_dq_oe  <= src_oe;
      cli_rdata    <= sdram_dq_in;
      if (arb_take) begin
        grant_id <= arb_idx;
        gnt_oh   <= arb_oh;
        rr_ptr   <= (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + IW'(1);
        wd_cnt   <= '0;
      end else if (state == S_GRANT && !wd_hit) begin
        wd_cnt <= wd_cnt + WW'(1);
      end
      if (wd_fire) err_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
- Parametrised command/bus arbiter for the SDRAM controller.
- Multiplexes the init engine, the auto-refresh engine and NCH client engines (read/write bursts, any mix) onto one SDRAM command/address/bank/DQ bus.
- Adds over the previous fixed write/read top-level mux:
  - round-robin client fairness
  - registered pin outputs
  - refresh-pending abort indication
  - grant watchdog with sticky error flag

Parameters:
NCH, 2, number of client channels (1..8)
AW, 12, SDRAM address width
BW, 2, bank address width
DW, 16, DQ width
TIMEOUT, 1023, max cycles a client may hold grant without cli_end; 0 disables the watchdog

Ports:
sclk  in  1  system clock; all logic on rising edge
srst  in  1  asynchronous active-high reset
init_done  in  1  init engine finished (level)
init_cmd  in  4  {cs_n,ras_n,cas_n,we_n} from init engine
init_addr  in  AW  address from init engine
aref_ask  in  1  refresh request (level until serviced)
aref_end  in  1  refresh sequence complete (1-cycle pulse)
aref_cmd  in  4  refresh engine command
aref_addr  in  AW  refresh engine address
aref_en  out  1  refresh engine enable
cli_ask  in  NCH  per-client request (level)
cli_end  in  NCH  per-client burst done (pulse)
cli_cmd  in  4*NCH  per-client command, channel i at [4i+3:4i]
cli_addr  in  AW*NCH  per-client address
cli_bank  in  BW*NCH  per-client bank
cli_wdata  in  DW*NCH  per-client write data
cli_oe  in  NCH  client drives DQ this cycle
cli_en  out  NCH  one-hot client enable
cli_abort  out  1  refresh pending while a client holds grant
cli_rdata  out  DW  registered DQ input, broadcast to all clients
grant_id  out  clog2(NCH) (min 1)  current/last granted channel
sdram_cmd  out  4  registered command to pins
sdram_addr  out  AW  registered address
sdram_bank  out  BW  registered bank
sdram_dq_out  out  DW  registered write data
sdram_dq_oe  out  1  registered DQ output enable; pad tristate is outside this block
sdram_dq_in  in  DW  DQ pad input
err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset values (srst high, asynchronous):
  - state=S_IDLE
  - sdram_cmd=4'b0111 (NOP)
  - sdram_addr, sdram_bank, sdram_dq_out, cli_rdata = 0
  - sdram_dq_oe=0, cli_en=0, aref_en=0, cli_abort=0
  - grant_id=0, rr pointer=0, watchdog=0, err_timeout=0
- States: S_IDLE, S_ARBIT, S_AREF, S_GRANT (one-hot).
- S_IDLE: source=init. init_done=1 -> S_ARBIT next cycle. cli_ask and aref_ask are ignored.
- S_ARBIT: source=NOP, oe=0.
  - aref_ask=1 -> S_AREF. Refresh has absolute priority.
  - Else any cli_ask -> S_GRANT. Winner is the first asserted channel at or after the rr pointer, modulo NCH.
  - On grant, grant_id=winner and the pointer is set to (winner+1) mod NCH.
  - Else stay in S_ARBIT.
- S_AREF: aref_en=1, source=refresh. aref_end=1 -> S_ARBIT.
- S_GRANT, granted channel g:
  - cli_en[g] = ~aref_ask (combinational); all other cli_en bits are 0.
  - cli_abort = aref_ask.
  - source = client g; sdram_dq_oe = cli_oe[g].
  - cli_end[g] -> S_ARBIT.
  - cli_end on any other channel is ignored.
- Pin registers: each cycle, sdram_cmd/addr/bank/dq_out/dq_oe <= selected source. Latency from source input to pin is exactly 1 sclk.
- cli_rdata <= sdram_dq_in every cycle (1-cycle latency). Clients account for the extra cycle in their CAS latency count.
- Watchdog:
  - Counts cycles in S_GRANT; clears on entry to S_GRANT.
  - On reaching TIMEOUT without cli_end[g]: force S_ARBIT, force NOP, set err_timeout=1.
  - err_timeout is cleared only by srst.
- Simultaneous events:
  - cli_end[g] with aref_ask in the same cycle -> S_ARBIT, then S_AREF on the next cycle.
  - aref_end with aref_ask still high -> S_ARBIT, then S_AREF again.
- NCH=1: the rr pointer is constant 0.
- Reset mid-burst: immediate NOP, oe=0, all enables dropped.

Decomposition:
- Package sdram_pkg holds:
  - CMD_NOP=4'b0111, CMD_PRE, CMD_AREF, CMD_MRS, CMD_ACT, CMD_RD, CMD_WR
  - state encodings S_IDLE..S_GRANT
- Sub-module sdram_rr_arbiter (NCH): combinational request vector + pointer -> one-hot winner and index.
- Pointer and the FSM stay in the parent.

Test Plan:
1. Reset, then init_done=1 at cycle 10 with init_cmd=4'b0010 -> sdram_cmd=0111 until the edge after init_cmd is applied in IDLE. Then init_cmd appears on pins 1 cycle later. State reaches S_ARBIT at cycle 11.
2. NCH=3, cli_ask=3'b111 held, each client pulses cli_end 8 cycles after grant -> grant order 0,1,2,0,1,2. cli_en is always one-hot.
3. Client 1 granted, aref_ask rises mid-burst -> cli_abort=1 and cli_en[1]=0 the same cycle. After cli_end[1] the FSM goes S_ARBIT then S_AREF, and aref_en=1 until aref_end.
4. Client 0 write with cli_oe=1, cli_wdata=16'hA5A5 -> sdram_dq_oe=1 and sdram_dq_out=A5A5 one cycle later. In S_ARBIT, oe returns to 0.
5. TIMEOUT=15, granted client never asserts cli_end -> after 15 cycles the FSM returns to S_ARBIT, sdram_cmd=0111, and err_timeout=1 stays set until srst.
6. srst pulse asserted mid-grant -> all outputs immediately take their reset values and state=S_IDLE.
